// File: rtl/scoreboard_hazard_unit_pkg.sv
// Shared types and encodings for the scoreboard hazard unit: producer ages,
// operand forward-select codes and the per-register scoreboard entry.
package scoreboard_hazard_unit_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_XM = 2'b01;
    localparam logic [1:0] FWD_MW = 2'b10;

    typedef enum logic [1:0] {
        AGE_IDLE = 2'd0,
        AGE_EX   = 2'd1,
        AGE_MEM  = 2'd2,
        AGE_WB   = 2'd3
    } age_t;

    typedef struct packed {
        age_t age;
        logic ld;
    } sb_entry_t;

    // A producer in WB retires: the register file's internal bypass covers it.
    function automatic age_t next_age(input age_t a);
        age_t n;
        case (a)
            AGE_EX:  n = AGE_MEM;
            AGE_MEM: n = AGE_WB;
            default: n = AGE_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/scoreboard_hazard_unit_if.sv
// Decode-side handshake between the issue logic and the hazard unit.
// master = decode stage driving the instruction, slave = hazard unit.
interface scoreboard_hazard_unit_if #(
    parameter int REG_ADDR_W  = 3,
    parameter int STALL_CNT_W = 16
);
    logic                   issue_valid;
    logic                   issue_wr;
    logic                   issue_is_load;
    logic [REG_ADDR_W-1:0]  issue_dst;
    logic                   rs1_valid;
    logic [REG_ADDR_W-1:0]  rs1;
    logic                   rs2_valid;
    logic [REG_ADDR_W-1:0]  rs2;
    logic                   flush;
    logic                   stall;
    logic [1:0]             fwd1_sel;
    logic [1:0]             fwd2_sel;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output issue_valid, issue_wr, issue_is_load, issue_dst,
        output rs1_valid, rs1, rs2_valid, rs2, flush,
        input  stall, fwd1_sel, fwd2_sel, stall_cnt
    );

    modport slave (
        input  issue_valid, issue_wr, issue_is_load, issue_dst,
        input  rs1_valid, rs1, rs2_valid, rs2, flush,
        output stall, fwd1_sel, fwd2_sel, stall_cnt
    );
endinterface

// File: rtl/scoreboard_hazard_unit_sb_lookup.sv
// Combinational hazard / forward decode for one source operand, given the
// scoreboard entry of the register it reads.
module sb_lookup
    import scoreboard_hazard_unit_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic      rs_valid,
    input  logic      issue_valid,
    input  sb_entry_t entry,
    output logic      haz,
    output logic [1:0] fwd_sel
);

    logic hit;

    assign hit = rs_valid & issue_valid & (entry.age != AGE_IDLE);

    // With bypass only a load still in EX is unservable; without bypass any
    // producer not yet in WB must be waited out.
    always_comb begin
        haz     = 1'b0;
        fwd_sel = FWD_RF;
        if (hit) begin
            if (FWD_EN) begin
                if (entry.age == AGE_EX) begin
                    if (entry.ld) begin
                        haz = 1'b1;
                    end else begin
                        fwd_sel = FWD_XM;
                    end
                end else if (entry.age == AGE_MEM) begin
                    fwd_sel = FWD_MW;
                end
            end else begin
                haz = (entry.age == AGE_EX) || (entry.age == AGE_MEM);
            end
        end
    end

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Decode-stage hazard unit: per-register scoreboard of in-flight writes,
// load-use / no-bypass stall generation, operand forward selects and a
// saturating stall counter.
module scoreboard_hazard_unit
    import scoreboard_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W  = 3,
    parameter bit FWD_EN      = 1'b1,
    parameter int STALL_CNT_W = 16
) (
    input logic                    clk,
    input logic                    rst,
    scoreboard_hazard_unit_if.slave hz
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    sb_entry_t              sb_q [NUM_REGS];
    sb_entry_t              sb_d [NUM_REGS];
    logic                   haz1;
    logic                   haz2;
    logic                   stall_int;
    logic                   accept;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    sb_lookup #(.FWD_EN(FWD_EN)) u_lookup_rs1 (
        .rs_valid    (hz.rs1_valid),
        .issue_valid (hz.issue_valid),
        .entry       (sb_q[hz.rs1]),
        .haz         (haz1),
        .fwd_sel     (hz.fwd1_sel)
    );

    sb_lookup #(.FWD_EN(FWD_EN)) u_lookup_rs2 (
        .rs_valid    (hz.rs2_valid),
        .issue_valid (hz.issue_valid),
        .entry       (sb_q[hz.rs2]),
        .haz         (haz2),
        .fwd_sel     (hz.fwd2_sel)
    );

    // A squashed instruction must not stall the front end nor enter the board.
    assign stall_int    = (haz1 | haz2) & ~hz.flush;
    assign accept       = hz.issue_valid & hz.issue_wr & ~stall_int & ~hz.flush;
    assign hz.stall     = stall_int;
    assign hz.stall_cnt = stall_cnt_q;

    // Youngest writer overwrites; flush kills producers in EX; the rest age.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            sb_d[i] = sb_q[i];
            if (accept && (hz.issue_dst == REG_ADDR_W'(i))) begin
                sb_d[i] = '{age: AGE_EX, ld: hz.issue_is_load};
            end else if (hz.flush && (sb_q[i].age == AGE_EX)) begin
                sb_d[i] = '{age: AGE_IDLE, ld: 1'b0};
            end else begin
                sb_d[i].age = next_age(sb_q[i].age);
                if (sb_d[i].age == AGE_IDLE) begin
                    sb_d[i].ld = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                sb_q[i] <= '{age: AGE_IDLE, ld: 1'b0};
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                sb_q[i] <= sb_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (stall_int && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

endmodule
